// File: rtl/operand_stack.sv
// operand_stack: LIFO operand stack answering one push/pop request at a time
// from the control unit. A rising edge on stacktrigger starts a request; the
// result is reported with a one-cycle stackdone pulse two clocks later.
module operand_stack #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stacktrigger,
  input  logic             stackpush,
  input  logic [WIDTH-1:0] stackwrite,
  input  logic             clear_err,
  output logic [WIDTH-1:0] stackread,
  output logic             stackdone,
  output logic             busy,
  output logic [PTR_W-1:0] depth,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic             r_trig_q;
  logic             r_op;
  logic [WIDTH-1:0] r_wdata;
  logic [PTR_W-1:0] r_sp;
  logic             r_empty;
  logic             r_full;
  logic [WIDTH-1:0] r_read;
  logic             r_ovf;
  logic             r_udf;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_req;
  logic             w_accept;
  logic             w_access;
  logic             w_push_ok;
  logic             w_push_ovf;
  logic             w_pop_ok;
  logic             w_pop_udf;
  logic [PTR_W-1:0] w_sp_next;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;

  // Rising-edge detect: a trigger held high fires only once.
  assign w_req = stacktrigger & ~r_trig_q;

  // Operation decode during the ACCESS cycle; full/empty decide error cases.
  assign w_push_ok  = w_access &  r_op & ~r_full;
  assign w_push_ovf = w_access &  r_op &  r_full;
  assign w_pop_ok   = w_access & ~r_op & ~r_empty;
  assign w_pop_udf  = w_access & ~r_op &  r_empty;

  assign w_wr_addr = ADDR_W'(r_sp);
  assign w_rd_addr = ADDR_W'(r_sp - PTR_W'(1));

  // Stack pointer saturates in [0, DEPTH] because errors leave it untouched.
  assign w_sp_next = w_push_ok ? r_sp + PTR_W'(1) :
                     w_pop_ok  ? r_sp - PTR_W'(1) : r_sp;

  assign stackread = r_read;
  assign depth     = r_sp;
  assign empty     = r_empty;
  assign full      = r_full;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic: IDLE -> ACCESS -> RESPOND -> IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_req) w_next_state = S_ACCESS;
      S_ACCESS:  w_next_state = S_RESPOND;
      S_RESPOND: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // State-decoded strobes; busy covers ACCESS and the RESPOND (done) cycle.
  always_comb begin
    w_accept  = 1'b0;
    w_access  = 1'b0;
    stackdone = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE:    w_accept = w_req;
      S_ACCESS:  begin w_access = 1'b1; busy = 1'b1; end
      S_RESPOND: begin stackdone = 1'b1; busy = 1'b1; end
      default:   ;
    endcase
  end

  // Control/datapath registers: request latch, pointer, status and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trig_q <= 1'b0;
      r_op     <= 1'b0;
      r_wdata  <= '0;
      r_sp     <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_read   <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_trig_q <= stacktrigger;
      if (w_accept) begin
        r_op    <= stackpush;
        r_wdata <= stackwrite;
      end
      r_sp    <= w_sp_next;
      r_empty <= (w_sp_next == '0);
      r_full  <= (w_sp_next == PTR_W'(DEPTH));
      if (w_pop_ok)       r_read <= r_mem[w_rd_addr];
      else if (w_pop_udf) r_read <= '0;
      if (w_push_ovf)     r_ovf <= 1'b1;
      else if (clear_err) r_ovf <= 1'b0;
      if (w_pop_udf)      r_udf <= 1'b1;
      else if (clear_err) r_udf <= 1'b0;
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[w_wr_addr] <= r_wdata;
  end

endmodule

// File: tb/tb_operand_stack.sv
// Bench for operand_stack: directed scenarios plus random push/pop traffic
// compared against a queue-based LIFO model.
module tb_operand_stack;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PTR_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             stacktrigger;
  logic             stackpush;
  logic [WIDTH-1:0] stackwrite;
  logic             clear_err;
  logic [WIDTH-1:0] stackread;
  logic             stackdone;
  logic             busy;
  logic [PTR_W-1:0] depth;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_read;
  bit               m_ovf;
  bit               m_udf;

  operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stacktrigger(stacktrigger), .stackpush(stackpush),
    .stackwrite(stackwrite), .clear_err(clear_err), .stackread(stackread),
    .stackdone(stackdone), .busy(busy), .depth(depth), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_read"}, stackread, m_read);
    check({tag, "_depth"}, 32'(depth), 32'(m_q.size()));
    check({tag, "_empty"}, 32'(empty), 32'(m_q.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(m_q.size() == DEPTH));
    check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_udf"}, 32'(underflow), 32'(m_udf));
  endtask

  // One request with a 1-cycle trigger pulse; optionally clear_err during ACCESS.
  task automatic do_op(input bit push, input logic [WIDTH-1:0] data, input bit clr);
    bit set_ovf = 0;
    bit set_udf = 0;
    int cyc;
    if (push) begin
      if (m_q.size() == DEPTH) set_ovf = 1;
      else m_q.push_back(data);
    end else begin
      if (m_q.size() == 0) begin set_udf = 1; m_read = '0; end
      else m_read = m_q.pop_back();
    end
    if (clr) begin m_ovf = 0; m_udf = 0; end
    if (set_ovf) m_ovf = 1;
    if (set_udf) m_udf = 1;

    @(negedge clk);
    stacktrigger = 1'b1;
    stackpush    = push;
    stackwrite   = data;
    @(negedge clk);
    check("early_done", 32'(stackdone), 32'd0);
    check("busy_access", 32'(busy), 32'd1);
    stacktrigger = 1'b0;
    stackwrite   = $urandom;
    if (clr) clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    cyc = 2;
    while (!stackdone && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check("done_latency", 32'(cyc), 32'd2);
    check("busy_done", 32'(busy), 32'd1);
    check_status(push ? "push" : "pop");
    @(negedge clk);
    check("done_pulse", 32'(stackdone), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    m_ovf = 0;
    m_udf = 0;
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_udf", 32'(underflow), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_q.delete();
    m_read = '0;
    m_ovf = 0;
    m_udf = 0;
  endtask

  initial begin
    int dones;
    rst = 1'b1;
    stacktrigger = 1'b0;
    stackpush = 1'b0;
    stackwrite = '0;
    clear_err = 1'b0;
    m_read = '0;
    m_ovf = 0;
    m_udf = 0;
    repeat (2) @(negedge clk);
    check("rst_done", 32'(stackdone), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_status("rst");
    rst = 1'b0;

    // Basic LIFO order.
    do_op(1, 32'd5, 0);
    do_op(1, 32'd7, 0);
    do_op(0, 32'd0, 0);
    do_op(0, 32'd0, 0);

    // Underflow, then clear.
    do_op(0, 32'd0, 0);
    do_clear();

    // Fill, overflow, pop top.
    for (int i = 1; i <= DEPTH; i++) do_op(1, 32'(i), 0);
    do_op(1, 32'hDEAD, 0);
    do_op(0, 32'd0, 0);

    // Set wins over clear in the same cycle.
    do_op(1, 32'd1, 0);
    do_op(1, 32'hBEEF, 1);

    // Trigger held high fires once.
    apply_reset();
    @(negedge clk);
    stacktrigger = 1'b1;
    stackpush = 1'b1;
    stackwrite = 32'd3;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (stackdone) dones++;
    end
    stacktrigger = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (stackdone) dones++;
    end
    m_q.push_back(32'd3);
    check("hold_dones", 32'(dones), 32'd1);
    check_status("hold");

    // Reset in the middle of a push.
    do_op(0, 32'd0, 0);
    do_op(0, 32'd0, 0);
    do_op(1, 32'd9, 0);
    do_op(0, 32'd0, 0);
    @(negedge clk);
    stacktrigger = 1'b1;
    stackpush = 1'b1;
    stackwrite = 32'd4;
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_q.delete();
    m_read = '0;
    m_ovf = 0;
    m_udf = 0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(stackdone), 32'd0);
    check_status("mid_rst");
    stacktrigger = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_op(0, 32'd0, 0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 19) do_clear();
      else do_op(r < 11, $urandom, ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
